// File: rtl/lane_arb_pkg.sv
// Shared types and defaults for the lane read arbiter.
package lane_arb_pkg;

    localparam int unsigned NUM_LANES_DEF      = 4;
    localparam int unsigned DATA_WIDTH_DEF     = 1024;
    localparam int unsigned ADDR_WIDTH_DEF     = 10;
    localparam int unsigned MEM_RD_LATENCY_DEF = 1;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned LANE_IDX_W = idx_width(NUM_LANES_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/lane_rr_picker.sv
// Combinational rotating-priority picker: the first eligible lane at or after
// ptr_i wins, wrapping modulo NUM_LANES.
module lane_rr_picker
    import lane_arb_pkg::*;
#(
    parameter int unsigned NUM_LANES = NUM_LANES_DEF,
    parameter int unsigned IDX_W     = LANE_IDX_W
) (
    input  logic [NUM_LANES-1:0] elig_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_LANES-1:0] pick_oh_o,
    output logic [IDX_W-1:0]     pick_idx_o,
    output logic                 any_o
);

    localparam int unsigned SW = IDX_W + 1;

    logic [SW-1:0] sum;

    // Scan from farthest to nearest offset so the nearest eligible lane wins.
    always_comb begin
        pick_oh_o  = '0;
        pick_idx_o = '0;
        any_o      = 1'b0;
        sum        = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + SW'(k);
            if (sum >= SW'(NUM_LANES)) begin
                sum = sum - SW'(NUM_LANES);
            end
            if (elig_i[sum[IDX_W-1:0]]) begin
                pick_oh_o                 = '0;
                pick_oh_o[sum[IDX_W-1:0]] = 1'b1;
                pick_idx_o                = sum[IDX_W-1:0];
                any_o                     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lane_read_arbiter.sv
// Shares one memory read port among NUM_LANES lanes. Each grant captures the
// read word into that lane's private data register, held until its next grant.
// Build option: LANE_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin.
module lane_read_arbiter
    import lane_arb_pkg::*;
#(
    parameter int unsigned NUM_LANES      = NUM_LANES_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned MEM_RD_LATENCY = MEM_RD_LATENCY_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_LANES-1:0]            lane_read_req,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0] lane_src_addr,
    output logic [NUM_LANES-1:0]            lane_read_gnt,
    output logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]           mem_rd_data,
    output logic                            busy
);

    localparam int unsigned    IDX_W     = idx_width(NUM_LANES);
    localparam int unsigned    CNT_W     = idx_width(MEM_RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MEM_RD_LATENCY - 1);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_LANES - 1);

    arb_state_e                      state_q, state_d;
    logic [IDX_W-1:0]                lane_q, lane_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic                            rd_en_q, rd_en_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_LANES-1:0]            gnt_q, gnt_d;
    logic                            busy_q, busy_d;
    logic [NUM_LANES-1:0]            armed_q, armed_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_q;
    logic                            cap_we;

    logic [NUM_LANES-1:0] elig;
    logic [NUM_LANES-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [IDX_W-1:0]     pick_ptr;

    assign elig = lane_read_req & armed_q;

`ifdef LANE_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Pointer moves to the lane after the one just served.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == CAPTURE) begin
            ptr_d = (lane_q == LAST_LANE) ? '0 : lane_q + IDX_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_ptr = ptr_q;
`endif

    lane_rr_picker #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .elig_i     (elig),
        .ptr_i      (pick_ptr),
        .pick_oh_o  (pick_oh),
        .pick_idx_o (pick_idx),
        .any_o      (pick_any)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        rd_en_d = 1'b0;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        cap_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    lane_d  = pick_idx;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (pick_oh[i]) begin
                            addr_d = lane_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        end
                    end
                    rd_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                cap_we  = 1'b1;
                gnt_d   = NUM_LANES'(1) << lane_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A grant disarms its lane; an idle request line re-arms it.
        armed_d = (armed_q | ~lane_read_req) & ~gnt_d;
        busy_d  = (state_d != IDLE);
    end

    // State and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            armed_q <= '1;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            armed_q <= armed_d;
        end
    end

    // Per-lane data registers; only the served lane's slice is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (cap_we && (lane_q == IDX_W'(i))) begin
                    data_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data;
                end
            end
        end
    end

    assign lane_read_gnt = gnt_q;
    assign lane_data     = data_q;
    assign mem_rd_en     = rd_en_q;
    assign mem_rd_addr   = addr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_lane_read_arbiter.sv
// Directed bench: a cycle table for a latency-1 instance plus hand sequences
// for a latency-3 instance (address hold, single strobe, reset mid-read).
module tb_lane_read_arbiter;

    localparam int unsigned NL = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 10;

    typedef struct {
        logic          rst;
        logic [NL-1:0] req;
        logic [NL*AW-1:0] addr;
        logic          en;
        logic [AW-1:0] eaddr;
        logic [NL-1:0] gnt;
        logic          busy;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-1 instance signals
    logic             rst1 = 1'b1;
    logic [NL-1:0]    req1 = '0;
    logic [NL*AW-1:0] addr1 = '0;
    logic [NL-1:0]    gnt1;
    logic [NL*DW-1:0] data1;
    logic             en1;
    logic [AW-1:0]    maddr1;
    logic [DW-1:0]    rdata1;
    logic             busy1;

    // Latency-3 instance signals
    logic             rst3 = 1'b1;
    logic [NL-1:0]    req3 = '0;
    logic [NL*AW-1:0] addr3 = '0;
    logic [NL-1:0]    gnt3;
    logic [NL*DW-1:0] data3;
    logic             en3;
    logic [AW-1:0]    maddr3;
    logic [DW-1:0]    rdata3;
    logic             busy3;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {22'h2B3C1D, a, 22'h15A5A5, ~a};
    endfunction

    lane_read_arbiter #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_RD_LATENCY(1)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .lane_read_req(req1), .lane_src_addr(addr1),
        .lane_read_gnt(gnt1), .lane_data(data1), .mem_rd_en(en1),
        .mem_rd_addr(maddr1), .mem_rd_data(rdata1), .busy(busy1)
    );

    lane_read_arbiter #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_RD_LATENCY(3)
    ) u_dut3 (
        .clk(clk), .rst(rst3), .lane_read_req(req3), .lane_src_addr(addr3),
        .lane_read_gnt(gnt3), .lane_data(data3), .mem_rd_en(en3),
        .mem_rd_addr(maddr3), .mem_rd_data(rdata3), .busy(busy3)
    );

    // Memory models: data valid L cycles after the strobe, zero otherwise.
    logic          v1_q = 1'b0;
    logic [AW-1:0] a1_q = '0;
    always @(posedge clk) begin
        v1_q <= en1;
        a1_q <= maddr1;
    end
    assign rdata1 = v1_q ? mem_word(a1_q) : '0;

    logic [2:0]    v3_q = '0;
    logic [AW-1:0] a3_0 = '0, a3_1 = '0, a3_2 = '0;
    always @(posedge clk) begin
        v3_q <= {v3_q[1:0], en3};
        a3_0 <= maddr3;
        a3_1 <= a3_0;
        a3_2 <= a3_1;
    end
    assign rdata3 = v3_q[2] ? mem_word(a3_2) : '0;

    task automatic chk(input string nm, input logic [NL*DW-1:0] act, input logic [NL*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [NL-1:0] q, input logic [NL*AW-1:0] a,
                                input logic e, input logic [AW-1:0] ea, input logic [NL-1:0] g,
                                input logic b);
        vec_t v;
        v.rst = r; v.req = q; v.addr = a; v.en = e; v.eaddr = ea; v.gnt = g; v.busy = b;
        return v;
    endfunction

    task automatic step3(input string nm, input logic e, input logic [AW-1:0] a,
                         input logic [NL-1:0] g, input logic b, input logic [NL*DW-1:0] d);
        @(posedge clk);
        #1;
        en_cnt += int'(en3);
        chk({nm, " en"},   (NL*DW)'(en3),    (NL*DW)'(e));
        chk({nm, " addr"}, (NL*DW)'(maddr3), (NL*DW)'(a));
        chk({nm, " gnt"},  (NL*DW)'(gnt3),   (NL*DW)'(g));
        chk({nm, " busy"}, (NL*DW)'(busy3),  (NL*DW)'(b));
        chk({nm, " data"}, data3,            d);
    endtask

    vec_t tbl [41];
    logic [NL*DW-1:0] mdl1 = '0;
    logic [NL*AW-1:0] a_one;
    logic [NL*AW-1:0] a_all;
    logic [NL*DW-1:0] exp3;

    initial begin
        a_one = {10'h000, 10'h055, 10'h000, 10'h000};
        a_all = {10'h103, 10'h102, 10'h101, 10'h100};
        //            rst   req      addr   en  eaddr    gnt      busy
        tbl[0]  = mk(1'b1, 4'b0000, a_one, 0, 10'h000, 4'b0000, 0);
        tbl[1]  = mk(1'b0, 4'b0100, a_one, 1, 10'h055, 4'b0000, 1);
        tbl[2]  = mk(1'b0, 4'b0100, a_one, 0, 10'h055, 4'b0000, 1);
        tbl[3]  = mk(1'b0, 4'b0100, a_one, 0, 10'h055, 4'b0100, 0);
        tbl[4]  = mk(1'b0, 4'b0100, a_one, 0, 10'h055, 4'b0000, 0);
        tbl[5]  = mk(1'b0, 4'b0000, a_one, 0, 10'h055, 4'b0000, 0);
        tbl[6]  = mk(1'b1, 4'b0000, a_all, 0, 10'h000, 4'b0000, 0);
        tbl[7]  = mk(1'b0, 4'b1111, a_all, 1, 10'h100, 4'b0000, 1);
        tbl[8]  = mk(1'b0, 4'b1111, a_all, 0, 10'h100, 4'b0000, 1);
        tbl[9]  = mk(1'b0, 4'b1111, a_all, 0, 10'h100, 4'b0001, 0);
        tbl[10] = mk(1'b0, 4'b1110, a_all, 1, 10'h101, 4'b0000, 1);
        tbl[11] = mk(1'b0, 4'b1110, a_all, 0, 10'h101, 4'b0000, 1);
        tbl[12] = mk(1'b0, 4'b1110, a_all, 0, 10'h101, 4'b0010, 0);
        tbl[13] = mk(1'b0, 4'b1100, a_all, 1, 10'h102, 4'b0000, 1);
        tbl[14] = mk(1'b0, 4'b1100, a_all, 0, 10'h102, 4'b0000, 1);
        tbl[15] = mk(1'b0, 4'b1100, a_all, 0, 10'h102, 4'b0100, 0);
        tbl[16] = mk(1'b0, 4'b1000, a_all, 1, 10'h103, 4'b0000, 1);
        tbl[17] = mk(1'b0, 4'b1000, a_all, 0, 10'h103, 4'b0000, 1);
        tbl[18] = mk(1'b0, 4'b1000, a_all, 0, 10'h103, 4'b1000, 0);
        tbl[19] = mk(1'b0, 4'b0000, a_all, 0, 10'h103, 4'b0000, 0);
        tbl[20] = mk(1'b0, 4'b0001, a_all, 1, 10'h100, 4'b0000, 1);
        tbl[21] = mk(1'b0, 4'b0001, a_all, 0, 10'h100, 4'b0000, 1);
        tbl[22] = mk(1'b0, 4'b0001, a_all, 0, 10'h100, 4'b0001, 0);
        tbl[23] = mk(1'b0, 4'b0000, a_all, 0, 10'h100, 4'b0000, 0);
        tbl[24] = mk(1'b0, 4'b0011, a_all, 1, 10'h101, 4'b0000, 1);
        tbl[25] = mk(1'b0, 4'b0011, a_all, 0, 10'h101, 4'b0000, 1);
        tbl[26] = mk(1'b0, 4'b0011, a_all, 0, 10'h101, 4'b0010, 0);
        tbl[27] = mk(1'b0, 4'b0001, a_all, 1, 10'h100, 4'b0000, 1);
        tbl[28] = mk(1'b0, 4'b0001, a_all, 0, 10'h100, 4'b0000, 1);
        tbl[29] = mk(1'b0, 4'b0001, a_all, 0, 10'h100, 4'b0001, 0);
        tbl[30] = mk(1'b0, 4'b0000, a_all, 0, 10'h100, 4'b0000, 0);
        tbl[31] = mk(1'b0, 4'b0010, a_all, 1, 10'h101, 4'b0000, 1);
        tbl[32] = mk(1'b0, 4'b0010, a_all, 0, 10'h101, 4'b0000, 1);
        tbl[33] = mk(1'b0, 4'b0010, a_all, 0, 10'h101, 4'b0010, 0);
        tbl[34] = mk(1'b0, 4'b0010, a_all, 0, 10'h101, 4'b0000, 0);
        tbl[35] = mk(1'b0, 4'b0010, a_all, 0, 10'h101, 4'b0000, 0);
        tbl[36] = mk(1'b0, 4'b0000, a_all, 0, 10'h101, 4'b0000, 0);
        tbl[37] = mk(1'b0, 4'b0010, a_all, 1, 10'h101, 4'b0000, 1);
        tbl[38] = mk(1'b0, 4'b0010, a_all, 0, 10'h101, 4'b0000, 1);
        tbl[39] = mk(1'b0, 4'b0010, a_all, 0, 10'h101, 4'b0010, 0);
        tbl[40] = mk(1'b0, 4'b0000, a_all, 0, 10'h101, 4'b0000, 0);

        // Table pass on the latency-1 instance: inputs for one cycle, outputs after the edge.
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            rst1  = tbl[i].rst;
            req1  = tbl[i].req;
            addr1 = tbl[i].addr;
            if (tbl[i].rst) mdl1 = '0;
            @(posedge clk);
            #1;
            for (int j = 0; j < int'(NL); j++) begin
                if (tbl[i].gnt[j]) mdl1[j*DW +: DW] = mem_word(tbl[i].eaddr);
            end
            chk($sformatf("v%0d en", i),   (NL*DW)'(en1),    (NL*DW)'(tbl[i].en));
            chk($sformatf("v%0d addr", i), (NL*DW)'(maddr1), (NL*DW)'(tbl[i].eaddr));
            chk($sformatf("v%0d gnt", i),  (NL*DW)'(gnt1),   (NL*DW)'(tbl[i].gnt));
            chk($sformatf("v%0d busy", i), (NL*DW)'(busy1),  (NL*DW)'(tbl[i].busy));
            chk($sformatf("v%0d data", i), data1,            mdl1);
        end

        // Latency-3: reset state, single strobe, address held across WAIT.
        @(negedge clk);
        chk("l3 rst busy", (NL*DW)'(busy3), '0);
        chk("l3 rst data", data3, '0);
        rst3  = 1'b0;
        @(negedge clk);
        req3  = 4'b0001;
        addr3 = {10'h000, 10'h000, 10'h0AA, 10'h033};
        step3("a1", 1'b1, 10'h033, 4'b0000, 1'b1, '0);
        addr3 = {10'h000, 10'h000, 10'h0AA, 10'h3FF};
        step3("a2", 1'b0, 10'h033, 4'b0000, 1'b1, '0);
        step3("a3", 1'b0, 10'h033, 4'b0000, 1'b1, '0);
        step3("a4", 1'b0, 10'h033, 4'b0000, 1'b1, '0);
        exp3 = {192'd0, mem_word(10'h033)};
        step3("a5", 1'b0, 10'h033, 4'b0001, 1'b0, exp3);
        chk("l3 strobe count", (NL*DW)'(en_cnt), (NL*DW)'(1));
        req3 = 4'b0000;
        step3("a6", 1'b0, 10'h033, 4'b0000, 1'b0, exp3);

        // Latency-3: reset during WAIT discards the read; held request restarts from lane 0.
        req3 = 4'b0011;
        step3("b1", 1'b1, 10'h0AA, 4'b0000, 1'b1, exp3);
        step3("b2", 1'b0, 10'h0AA, 4'b0000, 1'b1, exp3);
        #2;
        rst3 = 1'b1;
        #1;
        chk("b rst gnt",  (NL*DW)'(gnt3),   '0);
        chk("b rst busy", (NL*DW)'(busy3),  '0);
        chk("b rst en",   (NL*DW)'(en3),    '0);
        chk("b rst addr", (NL*DW)'(maddr3), '0);
        chk("b rst data", data3, '0);
        @(negedge clk);
        rst3 = 1'b0;
        step3("b3", 1'b1, 10'h3FF, 4'b0000, 1'b1, '0);
        step3("b4", 1'b0, 10'h3FF, 4'b0000, 1'b1, '0);
        step3("b5", 1'b0, 10'h3FF, 4'b0000, 1'b1, '0);
        step3("b6", 1'b0, 10'h3FF, 4'b0000, 1'b1, '0);
        exp3 = {192'd0, mem_word(10'h3FF)};
        step3("b7", 1'b0, 10'h3FF, 4'b0001, 1'b0, exp3);
        req3 = 4'b0000;
        step3("b8", 1'b0, 10'h3FF, 4'b0000, 1'b0, exp3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_read_arbiter.md
# lane_read_arbiter

Shares the single source-memory read port between `NUM_LANES` encode controllers, one per router lane. Each lane raises a read request with a source address. The arbiter picks one lane round-robin, performs the memory read, and captures the word into that lane's private data register. It then pulses the lane's grant. Each data register holds its word stable until that lane's next grant, so a lane can stream the word into its packet encoder for as long as it needs.

## Interface
- `NUM_LANES`, 4, number of requesting lanes (≥2)
- `DATA_WIDTH`, 1024, memory word width
- `ADDR_WIDTH`, 10, memory address width
- `MEM_RD_LATENCY`, 1, cycles from `mem_rd_en` high to `mem_rd_data` valid (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous reset, active-high
- `lane_read_req`  in  NUM_LANES  per-lane read request (level)
- `lane_src_addr`  in  NUM_LANES*ADDR_WIDTH  per-lane address; lane i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `lane_read_gnt`  out  NUM_LANES  one-hot, one-cycle grant pulse
- `lane_data`  out  NUM_LANES*DATA_WIDTH  per-lane held read data, same slicing as the addresses
- `mem_rd_en`  out  1  memory read strobe, one cycle
- `mem_rd_addr`  out  ADDR_WIDTH  memory read address
- `mem_rd_data`  in  DATA_WIDTH  memory read data
- `busy`  out  1  high in every state except IDLE

## Operation
- Reset (async, `rst`=1):
  - All outputs are 0, and every `lane_data` slice is 0.
  - State returns to IDLE.
  - The round-robin pointer is 0, so lane 0 has highest priority.
  - All `armed` bits are 1.
- Per-lane `armed` bit:
  - Cleared on the same edge that grants the lane.
  - Set on any edge where that lane's `lane_read_req` is 0.
- A lane is eligible when `lane_read_req[i] & armed[i]`. This prevents a re-grant while a lane still holds `req` for a few cycles after its grant.
- States:
  - **IDLE**
    - No eligible lane: stay in IDLE.
    - Otherwise: pick the first eligible lane at or after the pointer, wrapping modulo `NUM_LANES`.
    - On the next edge: latch the lane index, set `mem_rd_addr` to that lane's address, set `mem_rd_en`=1, clear the latency counter, go to WAIT.
  - **WAIT**
    - `mem_rd_en` is 0 from the second cycle in WAIT onward.
    - The counter increments each cycle.
    - When the counter reaches `MEM_RD_LATENCY`-1: go to CAPTURE.
  - **CAPTURE**
    - `mem_rd_data` is valid in this cycle.
    - On the next edge: write the word into the latched lane's `lane_data` slice, set `lane_read_gnt` for that lane to 1 (one-hot), clear its `armed` bit, set the pointer to (lane+1) mod `NUM_LANES`, go to IDLE.
- `lane_read_gnt` is 0 in every cycle except the one after CAPTURE.
- `mem_rd_addr` holds its last value between reads.
- The address is sampled only at issue. Later changes to `lane_src_addr` do not affect an in-flight read.
- A request dropped during WAIT or CAPTURE does not abort the read. The data is still captured and the grant still pulses.
- Simultaneous events:
  - A lane whose `req` falls on its own grant edge is re-armed on the following edge.
  - Requests arriving while busy are serviced in pointer order once the block returns to IDLE.
- Slices of non-granted lanes never change.

## Timing
- Latency:
  - Cycle 0: IDLE with an eligible request.
  - Cycle 1: `mem_rd_en`=1.
  - Cycle 1+L: `mem_rd_data` is sampled.
  - Cycle 2+L: grant pulse, with `lane_data` already updated.
- With L=1, the grant arrives 3 cycles after the request is seen.
- Back-to-back issue is possible from IDLE in cycle 2+L, giving peak throughput of one read per L+2 cycles.
- No combinational paths from inputs to outputs; all outputs are registered.
- Reset asserted mid-read discards the in-flight read. Grant is 0 and all lanes are re-armed.

## Configuration
- `LANE_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest-numbered eligible lane wins. The pointer is held at 0 and never updated.
  - Undefined (default): round-robin as described above.
- The `armed` masking applies in both modes.

## Structure
- Package `lane_arb_pkg`:
  - State enum: IDLE, WAIT, CAPTURE.
  - Default constants for `NUM_LANES`, `DATA_WIDTH`, `ADDR_WIDTH`.
  - Lane-index width localparam, $clog2(`NUM_LANES`).
- Sub-module `lane_rr_picker`:
  - Purely combinational.
  - Inputs: eligible vector and pointer.
  - Outputs: one-hot pick, index, and `any` flag.
  - Under `LANE_ARB_FIXED_PRIO_EN` it is used with the pointer tied to 0.

## Test plan
- Single request, L=1: lane 2 req with addr 0x055 at cycle 0.
  - Expect `mem_rd_en`=1 with `mem_rd_addr`=0x055 at cycle 1.
  - Expect `lane_read_gnt`=4'b0100 at cycle 3, with the slice equal to the memory word.
  - The other slices stay 0.
- All four lanes request together, held high until granted, then dropped: grants in order 0,1,2,3, spaced 3 cycles apart.
  - With `LANE_ARB_FIXED_PRIO_EN` and all lanes re-requesting: lane 0 wins each round.
- Lane 1 holds req for 2 cycles after its grant, and is the only requester: exactly one grant; a second grant only after req falls and rises again.
- L=3: `mem_rd_en` high for exactly 1 cycle; grant at cycle 5. Changing `lane_src_addr` during WAIT does not change `mem_rd_addr`.
- `rst` pulsed during WAIT:
  - No grant is issued and all `lane_data` slices read 0.
  - `busy`=0.
  - A held request is re-issued starting from lane 0 priority.
